elbeth_lsu_ctrl: RTL and testbench



---
 rtl/elbeth_lsu_ctrl_pkg.sv | 24 ++
 rtl/elbeth_lsu_ctrl_if.sv | 29 ++
 rtl/elbeth_lsu_align.sv | 50 +++++
 rtl/elbeth_lsu_ctrl.sv | 136 +++++++++++++
 tb/tb_elbeth_lsu_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/elbeth_lsu_ctrl_pkg.sv
// Shared definitions for the ELBETH load/store unit: access size encodings,
// controller state encoding and the misalignment rule.
package elbeth_lsu_ctrl_pkg;

  localparam logic [3:0] WORD     = 4'b0000;
  localparam logic [3:0] HALFWORD = 4'b0001;
  localparam logic [3:0] BYTE     = 4'b0010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_WAIT = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  // Unknown size encodings behave as WORD, so they share its alignment rule.
  function automatic logic lsu_misaligned(input logic [3:0] size, input logic [1:0] off);
    case (size)
      HALFWORD: return off[0];
      BYTE:     return 1'b0;
      default:  return (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/elbeth_lsu_ctrl_if.sv
// Data-memory bus between the LSU controller (master) and data memory (slave).
interface elbeth_lsu_ctrl_if;

  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_en;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    output dmem_en,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    input  dmem_en,
    output dmem_rdata,
    output dmem_ready
  );

endinterface

// File: rtl/elbeth_lsu_align.sv
// Combinational lane logic: store replication / byte enables from the live
// request, and load lane shift with zero/sign extension from the latched access.
module elbeth_lsu_align
  import elbeth_lsu_ctrl_pkg::*;
(
  input  logic [3:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,

  input  logic [3:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_signed_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      BYTE: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      HALFWORD: begin
        st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  always_comb begin
    shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = shifted;
    case (ld_size_i)
      BYTE:     ld_data_o = {{24{ld_signed_i & shifted[7]}}, shifted[7:0]};
      HALFWORD: ld_data_o = {{16{ld_signed_i & shifted[15]}}, shifted[15:0]};
      default:  ld_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/elbeth_lsu_ctrl.sv
// MEM-stage load/store controller: one data-memory transaction per request,
// pipeline stall while in flight, misalignment and bus-timeout detection.
module elbeth_lsu_ctrl
  import elbeth_lsu_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [3:0]               ctrl_data_size,
  input  logic                     ctrl_data_signed,
  elbeth_lsu_ctrl_if.master        dmem,
  output logic [31:0]              lsu_rdata,
  output logic                     lsu_stall,
  output logic                     exc_load_misaligned,
  output logic                     exc_store_misaligned,
  output logic                     exc_bus_error
);

  localparam int unsigned CW = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

  lsu_state_e  state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        en_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;
  logic [3:0]  size_q;
  logic        signed_q;
  logic [1:0]  off_q;
  logic        load_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  logic        idle;
  logic        req;
  logic        mis;
  logic        issue;
  logic        timeout;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  elbeth_lsu_align u_align (
    .st_size_i   (ctrl_data_size),
    .st_off_i    (mem_addr[1:0]),
    .st_data_i   (mem_wdata),
    .st_wdata_o  (st_wdata),
    .st_be_o     (st_be),
    .ld_size_i   (size_q),
    .ld_off_i    (off_q),
    .ld_signed_i (signed_q),
    .ld_rdata_i  (dmem.dmem_rdata),
    .ld_data_o   (ld_data)
  );

  assign idle    = (state_q == LSU_IDLE);
  assign req     = mem_read | mem_write;
  assign mis     = lsu_misaligned(ctrl_data_size, mem_addr[1:0]);
  assign issue   = idle & req & ~mis;
  assign cnt_d   = cnt_q + 1'b1;
  assign timeout = (32'(cnt_d) >= BUS_TIMEOUT);

  // Read wins when both directions are requested, including for exceptions.
  assign exc_load_misaligned  = idle & mem_read & mis;
  assign exc_store_misaligned = idle & ~mem_read & mem_write & mis;
  assign lsu_stall            = issue | (state_q == LSU_WAIT);

  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_en    = en_q;
  assign lsu_rdata       = rdata_q;
  assign exc_bus_error   = bus_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      en_q      <= 1'b0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
      size_q    <= '0;
      signed_q  <= 1'b0;
      off_q     <= '0;
      load_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (issue) begin
            state_q  <= LSU_WAIT;
            en_q     <= 1'b1;
            addr_q   <= {mem_addr[31:2], 2'b00};
            be_q     <= mem_read ? 4'b0000 : st_be;
            wdata_q  <= st_wdata;
            size_q   <= ctrl_data_size;
            signed_q <= ctrl_data_signed;
            off_q    <= mem_addr[1:0];
            load_q   <= mem_read;
            cnt_q    <= '0;
          end
        end
        LSU_WAIT: begin
          if (dmem.dmem_ready) begin
            state_q <= LSU_DONE;
            en_q    <= 1'b0;
            rdata_q <= load_q ? ld_data : 32'h0;
          end else if (timeout) begin
            state_q   <= LSU_DONE;
            en_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        LSU_DONE: begin
          // Result and bus error are a one-cycle pulse for the advancing pipeline.
          state_q   <= LSU_IDLE;
          rdata_q   <= '0;
          bus_err_q <= 1'b0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_elbeth_lsu_ctrl.sv
// Self-checking bench for elbeth_lsu_ctrl with a scoreboard of expected transaction results.
module tb_elbeth_lsu_ctrl;
  import elbeth_lsu_ctrl_pkg::*;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  ctrl_data_size;
  logic        ctrl_data_signed;
  logic [31:0] lsu_rdata;
  logic        lsu_stall, exc_load_misaligned, exc_store_misaligned, exc_bus_error;

  elbeth_lsu_ctrl_if bus ();

  elbeth_lsu_ctrl #(.BUS_TIMEOUT(TMO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .ctrl_data_size       (ctrl_data_size),
    .ctrl_data_signed     (ctrl_data_signed),
    .dmem                 (bus),
    .lsu_rdata            (lsu_rdata),
    .lsu_stall            (lsu_stall),
    .exc_load_misaligned  (exc_load_misaligned),
    .exc_store_misaligned (exc_store_misaligned),
    .exc_bus_error        (exc_bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          done_cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          obs_done_cyc, obs_en_cycles;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_be;
  logic        obs_err, obs_stall0, obs_en0;

  function automatic logic [31:0] exp_load(logic [31:0] w, int off, logic [3:0] sz, logic sg);
    logic [7:0]  b[4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (sz)
      BYTE:     return {{24{sg & b[off][7]}}, b[off]};
      HALFWORD: begin h = {b[off+1], b[off]}; return {{16{sg & h[15]}}, h}; end
      default:  return w;
    endcase
  endfunction

  function automatic exp_t make_exp(logic rd, logic [31:0] a, logic [3:0] sz, logic sg,
                                    logic [31:0] wd, logic [31:0] rdat, int ready_at);
    exp_t e;
    int   off;
    off        = int'(a[1:0]);
    e.addr     = {a[31:2], 2'b00};
    e.done_cyc = (ready_at > 0) ? ready_at + 1 : int'(TMO) + 1;
    e.err      = (ready_at == 0);
    e.be       = 4'b0000;
    e.wdata    = wd;
    e.rdata    = 32'h0;
    if (rd) begin
      if (ready_at > 0) e.rdata = exp_load(rdat, off, sz, sg);
    end else begin
      case (sz)
        BYTE:     begin e.be[off] = 1'b1; e.wdata = {4{wd[7:0]}}; end
        HALFWORD: begin e.be[off] = 1'b1; e.be[off+1] = 1'b1; e.wdata = {2{wd[15:0]}}; end
        default:  e.be = 4'b1111;
      endcase
    end
    return e;
  endfunction

  // Caller is at #1 after a rising edge; returns at #1 after the edge that leaves DONE.
  task automatic run_txn(logic rd, logic wr, logic [31:0] a, logic [3:0] sz, logic sg,
                         logic [31:0] wd, logic [31:0] rdat, int ready_at);
    bit done;
    done = 0;
    obs_done_cyc = -1; obs_en_cycles = 0;
    obs_rdata = 'x; obs_err = 1'bx; obs_addr = 'x; obs_be = 'x; obs_wdata = 'x;
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd;
    ctrl_data_size = sz; ctrl_data_signed = sg; bus.dmem_rdata = rdat;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      bus.dmem_ready = (ready_at != 0) && (cyc == ready_at);
      @(negedge clk);
      if (bus.dmem_en === 1'b1) obs_en_cycles++;
      if (cyc == 0) begin obs_stall0 = lsu_stall; obs_en0 = bus.dmem_en; end
      if (cyc == 1) begin obs_addr = bus.dmem_addr; obs_be = bus.dmem_be; obs_wdata = bus.dmem_wdata; end
      if (cyc >= 1 && lsu_stall === 1'b0) begin
        done = 1; obs_done_cyc = cyc; obs_rdata = lsu_rdata; obs_err = exc_bus_error;
      end
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; bus.dmem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; mem_read = 0; mem_write = 0; mem_addr = '0; mem_wdata = '0;
    ctrl_data_size = WORD; ctrl_data_signed = 0; bus.dmem_rdata = '0; bus.dmem_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if ({bus.dmem_en, bus.dmem_be, lsu_stall, exc_bus_error} !== 7'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got en/be/stall/err=%b want 0", {bus.dmem_en, bus.dmem_be, lsu_stall, exc_bus_error}); end
    n_tests++; if (lsu_rdata !== 32'h0 || bus.dmem_addr !== 32'h0)
      begin n_fail++; $display("FAIL reset_data: got rdata=%h addr=%h want 0", lsu_rdata, bus.dmem_addr); end
    @(posedge clk); #1; rst = 0;
  endtask

  task automatic test_signed_byte_load();
    exp_t e;
    sb.push_back(make_exp(1, 32'h1003, BYTE, 1, 32'h0, 32'h80AABBCC, 1));
    run_txn(1, 0, 32'h1003, BYTE, 1, 32'h0, 32'h80AABBCC, 1);
    e = sb.pop_front();
    n_tests++; if (obs_stall0 !== 1'b1 || obs_en0 !== 1'b0)
      begin n_fail++; $display("FAIL sbyte_cycle0: got stall=%b en=%b want 1/0", obs_stall0, obs_en0); end
    n_tests++; if (obs_addr !== e.addr || obs_be !== e.be)
      begin n_fail++; $display("FAIL sbyte_bus: got addr=%h be=%b want %h/%b", obs_addr, obs_be, e.addr, e.be); end
    n_tests++; if (obs_done_cyc !== e.done_cyc || obs_rdata !== e.rdata)
      begin n_fail++; $display("FAIL sbyte_result: got cyc=%0d rdata=%h want %0d/%h", obs_done_cyc, obs_rdata, e.done_cyc, e.rdata); end
  endtask

  task automatic test_halfword_load();
    exp_t e;
    sb.push_back(make_exp(1, 32'h2002, HALFWORD, 0, 32'h0, 32'h92345678, 4));
    run_txn(1, 0, 32'h2002, HALFWORD, 0, 32'h0, 32'h92345678, 4);
    e = sb.pop_front();
    n_tests++; if (obs_done_cyc !== e.done_cyc || obs_rdata !== e.rdata || obs_err !== 1'b0)
      begin n_fail++; $display("FAIL uhalf_result: got cyc=%0d rdata=%h err=%b want %0d/%h/0", obs_done_cyc, obs_rdata, obs_err, e.done_cyc, e.rdata); end
    n_tests++; if (obs_en_cycles !== e.done_cyc - 1)
      begin n_fail++; $display("FAIL uhalf_en_len: got %0d want %0d", obs_en_cycles, e.done_cyc - 1); end
  endtask

  task automatic test_byte_store();
    exp_t e;
    sb.push_back(make_exp(0, 32'h11, BYTE, 0, 32'h000000A5, 32'h0, 2));
    run_txn(0, 1, 32'h11, BYTE, 0, 32'h000000A5, 32'h0, 2);
    e = sb.pop_front();
    n_tests++; if (obs_addr !== e.addr || obs_be !== e.be || obs_wdata !== e.wdata)
      begin n_fail++; $display("FAIL bstore_bus: got addr=%h be=%b wdata=%h want %h/%b/%h", obs_addr, obs_be, obs_wdata, e.addr, e.be, e.wdata); end
    n_tests++; if (obs_done_cyc !== e.done_cyc || obs_rdata !== e.rdata)
      begin n_fail++; $display("FAIL bstore_done: got cyc=%0d rdata=%h want %0d/%h", obs_done_cyc, obs_rdata, e.done_cyc, e.rdata); end
  endtask

  task automatic test_misaligned();
    logic        rd_t [3] = '{1'b1, 1'b0, 1'b1};
    logic        wr_t [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] a_t  [3] = '{32'h6, 32'h1, 32'h3};
    logic [3:0]  sz_t [3] = '{WORD, HALFWORD, HALFWORD};
    for (int i = 0; i < 3; i++) begin
      logic en_seen;
      en_seen = 0;
      mem_read = rd_t[i]; mem_write = wr_t[i]; mem_addr = a_t[i];
      ctrl_data_size = sz_t[i]; ctrl_data_signed = 0; mem_wdata = 32'h5A5A5A5A;
      @(negedge clk);
      n_tests++; if (exc_load_misaligned !== rd_t[i] || exc_store_misaligned !== !rd_t[i] || lsu_stall !== 1'b0)
        begin n_fail++; $display("FAIL misal_%0d: got ld=%b st=%b stall=%b want %b/%b/0", i, exc_load_misaligned, exc_store_misaligned, lsu_stall, rd_t[i], !rd_t[i]); end
      repeat (3) begin @(negedge clk); if (bus.dmem_en !== 1'b0 || lsu_stall !== 1'b0) en_seen = 1; end
      n_tests++; if (en_seen !== 1'b0)
        begin n_fail++; $display("FAIL misal_noaccess_%0d: got en/stall activity=%b want 0", i, en_seen); end
      @(posedge clk); #1; mem_read = 0; mem_write = 0;
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb.push_back(make_exp(1, 32'h300, WORD, 0, 32'h0, 32'hFFFFFFFF, 0));
    run_txn(1, 0, 32'h300, WORD, 0, 32'h0, 32'hFFFFFFFF, 0);
    e = sb.pop_front();
    n_tests++; if (obs_en_cycles !== int'(TMO))
      begin n_fail++; $display("FAIL tmo_en_len: got %0d want %0d", obs_en_cycles, TMO); end
    n_tests++; if (obs_done_cyc !== e.done_cyc || obs_err !== e.err || obs_rdata !== e.rdata)
      begin n_fail++; $display("FAIL tmo_done: got cyc=%0d err=%b rdata=%h want %0d/%b/%h", obs_done_cyc, obs_err, obs_rdata, e.done_cyc, e.err, e.rdata); end
    @(negedge clk);
    n_tests++; if (exc_bus_error !== 1'b0)
      begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", exc_bus_error); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    mem_read = 1; mem_write = 0; mem_addr = 32'h40; ctrl_data_size = WORD;
    ctrl_data_signed = 0; bus.dmem_rdata = 32'hDEADBEEF; bus.dmem_ready = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1; mem_read = 0;
    @(negedge clk);
    n_tests++; if (bus.dmem_en !== 1'b1)
      begin n_fail++; $display("FAIL rmid_inflight: got en=%b want 1", bus.dmem_en); end
    @(posedge clk); #1; rst = 0; bus.dmem_ready = 1;
    @(negedge clk);
    n_tests++; if (bus.dmem_en !== 1'b0 || lsu_stall !== 1'b0)
      begin n_fail++; $display("FAIL rmid_idle: got en=%b stall=%b want 0/0", bus.dmem_en, lsu_stall); end
    @(posedge clk); #1; bus.dmem_ready = 0;
    @(negedge clk);
    n_tests++; if (lsu_rdata !== 32'h0 || exc_bus_error !== 1'b0 || bus.dmem_en !== 1'b0)
      begin n_fail++; $display("FAIL rmid_late_ready: got rdata=%h err=%b en=%b want 0/0/0", lsu_rdata, exc_bus_error, bus.dmem_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic        rd_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_t  [4] = '{32'h100, 32'h102, 32'h200, 32'h8};
    logic [3:0]  sz_t [4] = '{WORD, HALFWORD, WORD, 4'hF};
    logic        sg_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] wd_t [4] = '{32'h0, 32'h0, 32'hCAFEF00D, 32'h0};
    logic [31:0] rd_d [4] = '{32'h12345678, 32'h80010000, 32'h0, 32'hF00DFACE};
    int          rdy  [4] = '{1, 1, 2, 3};
    for (int i = 0; i < 4; i++)
      sb.push_back(make_exp(rd_t[i], a_t[i], sz_t[i], sg_t[i], wd_t[i], rd_d[i], rdy[i]));
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      run_txn(rd_t[i], !rd_t[i], a_t[i], sz_t[i], sg_t[i], wd_t[i], rd_d[i], rdy[i]);
      e = sb.pop_front();
      n_tests++; if (obs_rdata !== e.rdata || obs_done_cyc !== e.done_cyc || obs_en0 !== 1'b0)
        begin n_fail++; $display("FAIL b2b_%0d_result: got rdata=%h cyc=%0d en0=%b want %h/%0d/0", i, obs_rdata, obs_done_cyc, obs_en0, e.rdata, e.done_cyc); end
      n_tests++; if (obs_addr !== e.addr || obs_be !== e.be || (!rd_t[i] && obs_wdata !== e.wdata))
        begin n_fail++; $display("FAIL b2b_%0d_bus: got addr=%h be=%b wdata=%h want %h/%b/%h", i, obs_addr, obs_be, obs_wdata, e.addr, e.be, e.wdata); end
    end
  endtask

  initial begin
    test_reset();
    test_signed_byte_load();
    test_halfword_load();
    test_byte_store();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_tests++; if (sb.size() != 0)
      begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
